// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field widths, operand/sum types and the adder node state encoding.
package noc_pkg;

  localparam int TDATAW = 32;
  localparam int TDESTW = 4;
  localparam int OPW    = 8;

  typedef logic [TDESTW-1:0] node_id_t;
  typedef logic [OPW-1:0]    operand_t;
  typedef logic [OPW:0]      sum_t;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    CALC   = 2'd2,
    SEND   = 2'd3
  } adder_state_e;

endpackage

// File: rtl/axis_out_reg.sv
// Registered AXI-Stream master stage: a load captures one flit and raises valid for one beat.
// Flit is held stable until accepted; no buffering beyond that single beat.
module axis_out_reg #(
  parameter int                TDATAW = 32,
  parameter int                TDESTW = 4,
  parameter logic [TDESTW-1:0] DEST   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TDATAW-1:0] load_dat,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [TDATAW-1:0] m_tdata,
  output logic [TDESTW-1:0] m_tdest,
  output logic              m_tlast,
  output logic              xfer
);

  assign m_tdest = DEST;
  assign xfer    = m_tvalid & m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else if (load) begin
      m_tvalid <= 1'b1;
      m_tdata  <= load_dat;
      m_tlast  <= 1'b1;
    end else if (xfer) begin
      // Data is left in place after the handshake; only valid/last retire.
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_adder_node.sv
// NoC adder responder: collects two single-flit operands, returns their OPW+1-bit sum as one flit.
// Result valid two edges after operand B; S_TREADY is held low from B acceptance until one cycle after the result leaves.
module noc_adder_node #(
  parameter int TDATAW      = noc_pkg::TDATAW,
  parameter int TDESTW      = noc_pkg::TDESTW,
  parameter int OPW         = noc_pkg::OPW,
  parameter int NODE_ID     = 1,
  parameter int RESULT_DEST = 0,
  parameter int CNTW        = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              S_TVALID,
  output logic              S_TREADY,
  input  logic [TDATAW-1:0] S_TDATA,
  input  logic [TDESTW-1:0] S_TDEST,
  input  logic              S_TLAST,
  output logic              M_TVALID,
  input  logic              M_TREADY,
  output logic [TDATAW-1:0] M_TDATA,
  output logic [TDESTW-1:0] M_TDEST,
  output logic              M_TLAST,
  output logic [CNTW-1:0]   RESULT_COUNT,
  output logic [CNTW-1:0]   DROP_COUNT,
  output logic              BUSY
);

  import noc_pkg::*;

  adder_state_e    state_q, state_d;
  logic            s_rdy_q;
  logic [OPW-1:0]  a_q, b_q;
  logic [OPW:0]    sum;
  logic [CNTW-1:0] result_cnt, drop_cnt;
  logic            beat, good, load_a, load_b, load_out, xfer;
  logic            unused_tdata;

  assign beat         = S_TVALID & s_rdy_q;
  assign good         = (S_TDEST == TDESTW'(NODE_ID)) & S_TLAST;
  assign sum          = {1'b0, a_q} + {1'b0, b_q};
  assign unused_tdata = ^S_TDATA[TDATAW-1:OPW];

  always_comb begin
    state_d  = state_q;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_out = 1'b0;
    case (state_q)
      WAIT_A: if (beat && good) begin
        load_a  = 1'b1;
        state_d = WAIT_B;
      end
      WAIT_B: if (beat && good) begin
        load_b  = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        load_out = 1'b1;
        state_d  = SEND;
      end
      SEND: if (xfer) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= WAIT_A;
      s_rdy_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      state_q <= state_d;
      // Ready returns one cycle after the result handshake, never in the SEND->WAIT_A edge itself.
      s_rdy_q <= ((state_d == WAIT_A) || (state_d == WAIT_B)) && (state_q != SEND);
      if (load_a) a_q <= S_TDATA[OPW-1:0];
      if (load_b) b_q <= S_TDATA[OPW-1:0];
      if (beat && !good) drop_cnt <= drop_cnt + CNTW'(1);
      if (xfer) result_cnt <= result_cnt + CNTW'(1);
    end
  end

  axis_out_reg #(
    .TDATAW (TDATAW),
    .TDESTW (TDESTW),
    .DEST   (TDESTW'(RESULT_DEST))
  ) u_out (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (load_out),
    .load_dat (TDATAW'(sum)),
    .m_tvalid (M_TVALID),
    .m_tready (M_TREADY),
    .m_tdata  (M_TDATA),
    .m_tdest  (M_TDEST),
    .m_tlast  (M_TLAST),
    .xfer     (xfer)
  );

  assign S_TREADY     = s_rdy_q;
  assign RESULT_COUNT = result_cnt;
  assign DROP_COUNT   = drop_cnt;
  assign BUSY         = (state_q != WAIT_A);

endmodule

// File: tb/tb_noc_adder_node.sv
// Directed bench for noc_adder_node: table of operand pairs plus hand-written latency, stall, drop and reset sequences.
module tb_noc_adder_node;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tdest = '0;
  logic        s_tlast = 1'b0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tdest;
  logic        m_tlast;
  logic [15:0] result_count;
  logic [15:0] drop_count;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int exp_res = 0;
  int exp_drop = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] sum;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  noc_adder_node #(
    .TDATAW(32), .TDESTW(4), .OPW(8), .NODE_ID(1), .RESULT_DEST(0), .CNTW(16)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .S_TVALID(s_tvalid), .S_TREADY(s_tready), .S_TDATA(s_tdata), .S_TDEST(s_tdest), .S_TLAST(s_tlast),
    .M_TVALID(m_tvalid), .M_TREADY(m_tready), .M_TDATA(m_tdata), .M_TDEST(m_tdest), .M_TLAST(m_tlast),
    .RESULT_COUNT(result_count), .DROP_COUNT(drop_count), .BUSY(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_flit(input logic [7:0] d, input logic [3:0] dst, input logic last);
    bit ok = 0;
    s_tvalid = 1'b1;
    s_tdata  = {24'h0, d};
    s_tdest  = dst;
    s_tlast  = last;
    for (int i = 0; i < 50; i++) begin
      if (s_tready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("send_accept_timeout", {31'h0, s_tready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50; i++) begin
      if (m_tvalid) break;
      @(negedge clk);
    end
    chk(name, {31'h0, m_tvalid}, 32'h1);
  endtask

  // Collects one result with M_TREADY high; returns at the negedge after the handshake.
  task automatic recv(input string name, input logic [31:0] exp);
    m_tready = 1'b1;
    wait_valid({name, "_vld"});
    chk({name, "_data"}, m_tdata, exp);
    chk({name, "_last"}, {31'h0, m_tlast}, 32'h1);
    chk({name, "_dest"}, {28'h0, m_tdest}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    exp_res++;
    chk({name, "_rcnt"}, {16'h0, result_count}, exp_res);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_res  = 0;
    exp_drop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] lcg;
    logic [7:0]  ra, rb;
    logic [31:0] held;

    vecs[0] = '{8'h05, 8'h0A, 32'h00F};
    vecs[1] = '{8'hFF, 8'hFF, 32'h1FE};
    vecs[2] = '{8'h00, 8'h00, 32'h000};
    vecs[3] = '{8'hFF, 8'h01, 32'h100};
    vecs[4] = '{8'h7F, 8'h80, 32'h0FF};
    vecs[5] = '{8'h02, 8'h03, 32'h005};

    // Reset state
    #3;
    chk("rst_s_tready", {31'h0, s_tready}, 32'h0);
    chk("rst_m_tvalid", {31'h0, m_tvalid}, 32'h0);
    chk("rst_m_tdata", m_tdata, 32'h0);
    chk("rst_m_tlast", {31'h0, m_tlast}, 32'h0);
    chk("rst_m_tdest", {28'h0, m_tdest}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rcnt", {16'h0, result_count}, 32'h0);
    chk("rst_dcnt", {16'h0, drop_count}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", {31'h0, s_tready}, 32'h1);

    // Basic add with exact latency: B accepted at edge n, result handshake at edge n+2
    m_tready = 1'b1;
    send_flit(8'h05, 4'd1, 1'b1);
    chk("basic_busy_wait_b", {31'h0, busy}, 32'h1);
    send_flit(8'h0A, 4'd1, 1'b1);
    chk("basic_n_vld", {31'h0, m_tvalid}, 32'h0);
    chk("basic_n_rdy", {31'h0, s_tready}, 32'h0);
    @(negedge clk);
    chk("basic_n1_vld", {31'h0, m_tvalid}, 32'h1);
    chk("basic_n1_data", m_tdata, 32'h00F);
    chk("basic_n1_dest", {28'h0, m_tdest}, 32'h0);
    chk("basic_n1_last", {31'h0, m_tlast}, 32'h1);
    @(negedge clk);
    exp_res++;
    chk("basic_n2_vld", {31'h0, m_tvalid}, 32'h0);
    chk("basic_n2_last", {31'h0, m_tlast}, 32'h0);
    chk("basic_n2_rcnt", {16'h0, result_count}, exp_res);
    chk("basic_n2_rdy", {31'h0, s_tready}, 32'h0);
    @(negedge clk);
    chk("basic_n3_rdy", {31'h0, s_tready}, 32'h1);
    chk("basic_n3_busy", {31'h0, busy}, 32'h0);

    // Table of operand pairs
    for (int i = 0; i < 6; i++) begin
      send_flit(vecs[i].a, 4'd1, 1'b1);
      send_flit(vecs[i].b, 4'd1, 1'b1);
      recv($sformatf("vec%0d", i), vecs[i].sum);
    end

    // Backpressure: result held stable for 10 stalled cycles
    m_tready = 1'b0;
    send_flit(8'h80, 4'd1, 1'b1);
    send_flit(8'h01, 4'd1, 1'b1);
    wait_valid("bp_vld");
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_vld", {31'h0, m_tvalid}, 32'h1);
      chk("bp_hold_data", m_tdata, 32'h081);
      chk("bp_hold_rdy", {31'h0, s_tready}, 32'h0);
      @(negedge clk);
    end
    held = m_tdata;
    chk("bp_pre_rcnt", {16'h0, result_count}, exp_res);
    m_tready = 1'b1;
    @(negedge clk);
    exp_res++;
    chk("bp_xfer_vld", {31'h0, m_tvalid}, 32'h0);
    chk("bp_xfer_rcnt", {16'h0, result_count}, exp_res);
    chk("bp_data_kept", held, 32'h081);

    // Misrouted and bad-TLAST flits are swallowed without advancing the FSM
    send_flit(8'h44, 4'd3, 1'b1);
    send_flit(8'h55, 4'd1, 1'b0);
    exp_drop += 2;
    chk("drop_cnt", {16'h0, drop_count}, exp_drop);
    chk("drop_busy", {31'h0, busy}, 32'h0);
    send_flit(8'h02, 4'd1, 1'b1);
    send_flit(8'h66, 4'd2, 1'b1);
    exp_drop++;
    chk("drop_cnt_in_b", {16'h0, drop_count}, exp_drop);
    send_flit(8'h03, 4'd1, 1'b1);
    recv("drop_sum", 32'h005);

    // Reset while the result is pending
    m_tready = 1'b0;
    send_flit(8'h01, 4'd1, 1'b1);
    send_flit(8'h02, 4'd1, 1'b1);
    wait_valid("rst_mid_vld");
    rst_n = 1'b0;
    #1;
    exp_res  = 0;
    exp_drop = 0;
    chk("rst_mid_vld_low", {31'h0, m_tvalid}, 32'h0);
    chk("rst_mid_rcnt", {16'h0, result_count}, 32'h0);
    chk("rst_mid_dcnt", {16'h0, drop_count}, 32'h0);
    chk("rst_mid_data", m_tdata, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_rdy", {31'h0, s_tready}, 32'h1);
    send_flit(8'h01, 4'd1, 1'b1);
    send_flit(8'h01, 4'd1, 1'b1);
    recv("rst_mid_sum", 32'h002);

    // Stream of 10 pseudo-random pairs from a fixed-seed LCG
    pulse_reset();
    lcg = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      lcg = lcg * 32'd1103515245 + 32'd12345;
      ra  = lcg[23:16];
      lcg = lcg * 32'd1103515245 + 32'd12345;
      rb  = lcg[23:16];
      send_flit(ra, 4'd1, 1'b1);
      send_flit(rb, 4'd1, 1'b1);
      recv($sformatf("stream%0d", i), {23'h0, {1'b0, ra} + {1'b0, rb}});
    end
    chk("stream_rcnt", {16'h0, result_count}, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
